bp_io_mmio_responder: RTL and testbench
=======================================

BP_IO_MMIO_RESPONDER -- requirements
Module: bp_io_mmio_responder

Interface
REQ-001 SHALL have parameter flit_width_p, default 64: IO NoC flit width.
REQ-002 SHALL have parameter cord_width_p, default 7: IO NoC coordinate width.
REQ-003 SHALL have parameter len_width_p, default 3: packet length field width.
REQ-004 SHALL have parameter num_regs_p, default 8: number of 64-bit MMIO registers, power of two, 2..8.
REQ-005 SHALL have port clk_i, input, 1: single clock, all state on posedge.
REQ-006 SHALL have port reset_i, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port my_cord_i, input, cord_width_p: this endpoint's IO NoC coordinate.
REQ-008 SHALL have ports cmd_flit_i (input, flit_width_p), cmd_v_i (input, 1) and cmd_ready_and_o (output, 1): inbound command link, ready-and handshake.
REQ-009 SHALL have ports resp_flit_o (output, flit_width_p), resp_v_o (output, 1) and resp_ready_and_i (input, 1): outbound response link, ready-and handshake.
REQ-010 SHALL have port regs_o, output, num_regs_p*64: flattened register contents, reg i at bits [64i+63:64i].

Function
REQ-011 SHALL use this header flit format for both directions: [6:0] dst cord, [9:7] len (payload flits following), [16:10] src cord, [18:17] opcode (0 read, 1 write, 2/3 unsupported), [21:19] reg index, [22] error, remaining bits zero.
REQ-012 SHALL transfer a flit only in a cycle where valid and ready_and are both high.
REQ-013 SHALL implement FSM states READY, RECV, DRAIN, RESP_HDR and RESP_DATA; reset state is READY.
REQ-014 SHALL in READY assert cmd_ready_and_o; on header accept it SHALL latch src cord, opcode, index and len.
- Read with len=0: to RESP_HDR.
- Write with len=1: to RECV.
- Any other opcode/len combination: latch error=1, and go to DRAIN if len>0, else to RESP_HDR.
REQ-015 SHALL in RECV assert cmd_ready_and_o; on accept it SHALL write the flit's low 64 bits to regs[index] and go to RESP_HDR.
REQ-016 SHALL in DRAIN accept and discard exactly len flits (down-counter), then go to RESP_HDR.
REQ-017 SHALL ignore the high index bits beyond log2(num_regs_p) (index wraps modulo num_regs_p); this is not an error.
REQ-018 SHALL deassert cmd_ready_and_o in RESP_HDR and RESP_DATA, so that one command is outstanding at a time.
REQ-019 SHALL drive the response header in RESP_HDR with:
- dst = latched src cord
- src = my_cord_i
- opcode and index echoed from the command
- error as latched
- len=1 for a successful read, else 0.
REQ-020 SHALL, on header accept, go to RESP_DATA if len=1, else to READY.
REQ-021 SHALL in RESP_DATA drive resp_flit_o = zero-extended regs[index] sampled at header acceptance, and on accept go to READY.
REQ-022 SHALL hold resp_flit_o stable while resp_v_o=1 and resp_ready_and_i=0.
REQ-023 SHALL give a best-case latency of header-in to response-header-valid of 1 cycle (read) and data-in to response-header-valid of 1 cycle (write); the response SHALL be registered, with no combinational input-to-output path.
REQ-024 SHALL make a write visible on regs_o in the cycle after data acceptance.

Reset
REQ-025 SHALL while reset_i is high force: FSM=READY, all registers=0, cmd_ready_and_o=0, resp_v_o=0, resp_flit_o=0, regs_o=0.
REQ-026 SHALL on reset mid-packet discard the partial command and any pending response; post-reset the first flit accepted SHALL be treated as a header.

Verification
REQ-027 SHALL cover: write reg 3, src=5, data 0xDEADBEEF_00000001 -> ack header dst=5, opcode=1, index=3, len=0, err=0; regs_o[255:192]=0xDEADBEEF_00000001.
REQ-028 SHALL cover: read reg 3 after REQ-027 -> header len=1, err=0, then data flit 0xDEADBEEF_00000001.
REQ-029 SHALL cover: opcode=2, len=2 -> both payload flits consumed, single header err=1, len=0, no register changed.
REQ-030 SHALL cover: read with resp_ready_and_i held low 10 cycles -> resp_v_o stays 1, flit constant, cmd_ready_and_o=0 throughout, then header and data delivered in order.
REQ-031 SHALL cover: write index 9 with num_regs_p=8 -> reg 1 updated, err=0.
REQ-032 SHALL cover: reset asserted after write header, before data -> all regs 0; a following read of reg 0 returns 0.

Source files
------------

// File: rtl/bp_io_mmio_responder_if.sv
// Command/response link bundle for the IO NoC MMIO responder.
// Both links use a ready-and handshake: a flit moves when valid and ready are both high.
interface bp_io_mmio_responder_if #(
    parameter int unsigned flit_width_p = 64
);
    logic [flit_width_p-1:0] cmd_flit_i;
    logic                    cmd_v_i;
    logic                    cmd_ready_and_o;
    logic [flit_width_p-1:0] resp_flit_o;
    logic                    resp_v_o;
    logic                    resp_ready_and_i;

    // Responder side
    modport slave (
        input  cmd_flit_i,
        input  cmd_v_i,
        output cmd_ready_and_o,
        output resp_flit_o,
        output resp_v_o,
        input  resp_ready_and_i
    );

    // Requester side
    modport master (
        output cmd_flit_i,
        output cmd_v_i,
        input  cmd_ready_and_o,
        input  resp_flit_o,
        input  resp_v_o,
        output resp_ready_and_i
    );
endinterface

// File: rtl/bp_io_mmio_responder.sv
// IO NoC MMIO responder: a small bank of 64-bit registers reached by single-flit read
// and two-flit write commands. One command is outstanding at a time; every command gets a
// header response, and a successful read gets one extra data flit.
module bp_io_mmio_responder #(
    parameter int unsigned flit_width_p = 64,
    parameter int unsigned cord_width_p = 7,
    parameter int unsigned len_width_p  = 3,
    parameter int unsigned num_regs_p   = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [cord_width_p-1:0]    my_cord_i,
    bp_io_mmio_responder_if.slave      io,
    output logic [num_regs_p*64-1:0]   regs_o
);

    // Header field positions
    localparam int unsigned LenLsb   = cord_width_p;
    localparam int unsigned SrcLsb   = cord_width_p + len_width_p;
    localparam int unsigned OpLsb    = 2 * cord_width_p + len_width_p;
    localparam int unsigned IdxLsb   = OpLsb + 2;
    localparam int unsigned ErrBit   = IdxLsb + 3;
    localparam int unsigned SelWidth = (num_regs_p > 1) ? $clog2(num_regs_p) : 1;

    localparam logic [1:0] OpRead  = 2'd0;
    localparam logic [1:0] OpWrite = 2'd1;

    typedef enum logic [2:0] {
        StReady,
        StRecv,
        StDrain,
        StRespHdr,
        StRespData
    } state_e;

    state_e                  state_q, state_d;
    logic [cord_width_p-1:0] src_q, src_d;
    logic [1:0]              op_q, op_d;
    logic [2:0]              idx_q, idx_d;
    logic                    err_q, err_d;
    logic [len_width_p-1:0]  cnt_q, cnt_d;
    logic [flit_width_p-1:0] resp_flit_q, resp_flit_d;
    logic [63:0]             regs_q [num_regs_p];

    logic                    cmd_ready;
    logic                    cmd_fire;
    logic                    resp_fire;
    logic                    wr_en;
    logic                    has_data_q;
    logic                    has_data_d;
    logic [SelWidth-1:0]     sel;
    logic [flit_width_p-1:0] resp_hdr;

    // Incoming header fields
    logic [cord_width_p-1:0] in_src;
    logic [len_width_p-1:0]  in_len;
    logic [1:0]              in_op;
    logic [2:0]              in_idx;

    assign in_src = io.cmd_flit_i[SrcLsb +: cord_width_p];
    assign in_len = io.cmd_flit_i[LenLsb +: len_width_p];
    assign in_op  = io.cmd_flit_i[OpLsb +: 2];
    assign in_idx = io.cmd_flit_i[IdxLsb +: 3];

    // Reset gates ready so nothing is accepted while reset is held.
    assign cmd_ready = ~reset_i &
                       ((state_q == StReady) | (state_q == StRecv) | (state_q == StDrain));
    assign cmd_fire  = io.cmd_v_i & cmd_ready;
    assign resp_fire = io.resp_v_o & io.resp_ready_and_i;

    assign io.cmd_ready_and_o = cmd_ready;
    assign io.resp_v_o        = ~reset_i & ((state_q == StRespHdr) | (state_q == StRespData));
    assign io.resp_flit_o     = resp_flit_q;

    // High index bits wrap silently
    assign sel        = idx_q[SelWidth-1:0];
    assign has_data_q = (op_q == OpRead) & ~err_q;
    assign has_data_d = (op_d == OpRead) & ~err_d;

    // Next-state, command field capture and response flit generation
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        op_d        = op_q;
        idx_d       = idx_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        resp_flit_d = resp_flit_q;
        wr_en       = 1'b0;
        resp_hdr    = '0;

        unique case (state_q)
            StReady: begin
                if (cmd_fire) begin
                    src_d = in_src;
                    op_d  = in_op;
                    idx_d = in_idx;
                    cnt_d = in_len;
                    err_d = 1'b0;
                    if ((in_op == OpRead) && (in_len == '0)) begin
                        state_d = StRespHdr;
                    end else if ((in_op == OpWrite) && (in_len == len_width_p'(1))) begin
                        state_d = StRecv;
                    end else begin
                        err_d   = 1'b1;
                        state_d = (in_len != '0) ? StDrain : StRespHdr;
                    end
                end
            end
            StRecv: begin
                if (cmd_fire) begin
                    wr_en   = 1'b1;
                    state_d = StRespHdr;
                end
            end
            StDrain: begin
                if (cmd_fire) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == len_width_p'(1)) begin
                        state_d = StRespHdr;
                    end
                end
            end
            StRespHdr: begin
                if (resp_fire) begin
                    resp_flit_d = '0;
                    if (has_data_q) begin
                        // Data is snapshotted here, at header acceptance
                        resp_flit_d[63:0] = regs_q[sel];
                        state_d           = StRespData;
                    end else begin
                        state_d = StReady;
                    end
                end
            end
            StRespData: begin
                if (resp_fire) begin
                    resp_flit_d = '0;
                    state_d     = StReady;
                end
            end
            default: state_d = StReady;
        endcase

        // Header is registered on entry so it is valid the cycle after the last command flit.
        if ((state_d == StRespHdr) && (state_q != StRespHdr)) begin
            resp_hdr[0 +: cord_width_p]      = src_d;
            resp_hdr[LenLsb +: len_width_p]  = {{(len_width_p-1){1'b0}}, has_data_d};
            resp_hdr[SrcLsb +: cord_width_p] = my_cord_i;
            resp_hdr[OpLsb +: 2]             = op_d;
            resp_hdr[IdxLsb +: 3]            = idx_d;
            resp_hdr[ErrBit]                 = err_d;
            resp_flit_d                      = resp_hdr;
        end
    end

    // FSM and command context registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StReady;
            src_q       <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            resp_flit_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            resp_flit_q <= resp_flit_d;
        end
    end

    // MMIO register bank
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(num_regs_p); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[sel] <= io.cmd_flit_i[63:0];
        end
    end

    // Flatten the register bank
    always_comb begin
        regs_o = '0;
        for (int i = 0; i < int'(num_regs_p); i++) begin
            regs_o[i*64 +: 64] = regs_q[i];
        end
    end

endmodule

// File: tb/tb_bp_io_mmio_responder.sv
// Directed bench for bp_io_mmio_responder: a table of command transactions with hand-computed
// responses, followed by back-pressure and mid-packet reset sequences.
module tb_bp_io_mmio_responder;

    localparam int unsigned NumRegs = 8;
    localparam logic [6:0]  MyCord  = 7'd12;

    logic                    clk;
    logic                    reset;
    logic [6:0]              my_cord;
    logic [NumRegs*64-1:0]   regs;

    int n_checks = 0;
    int n_fail   = 0;

    bp_io_mmio_responder_if #(.flit_width_p(64)) bus ();

    bp_io_mmio_responder #(
        .flit_width_p(64),
        .cord_width_p(7),
        .len_width_p (3),
        .num_regs_p  (NumRegs)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .my_cord_i(my_cord),
        .io       (bus),
        .regs_o   (regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Header layout: [6:0] dst, [9:7] len, [16:10] src, [18:17] op, [21:19] idx, [22] err
    function automatic logic [63:0] mk_hdr(input logic [6:0] dst, input logic [2:0] len,
                                           input logic [6:0] src, input logic [1:0] op,
                                           input logic [2:0] idx, input logic err);
        logic [63:0] h;
        h        = '0;
        h[6:0]   = dst;
        h[9:7]   = len;
        h[16:10] = src;
        h[18:17] = op;
        h[21:19] = idx;
        h[22]    = err;
        return h;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic send_flit(input logic [63:0] f);
        int n;
        n = 0;
        @(negedge clk);
        bus.cmd_v_i    = 1'b1;
        bus.cmd_flit_i = f;
        while (!bus.cmd_ready_and_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("cmd_ready_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        bus.cmd_v_i    = 1'b0;
        bus.cmd_flit_i = '0;
    endtask

    task automatic recv_flit(output logic [63:0] f, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        bus.resp_ready_and_i = 1'b1;
        while (!bus.resp_v_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("resp_valid_timeout", 64'(n), 64'd0);
        lat = n;
        f   = bus.resp_flit_o;
        @(posedge clk);
        #1;
        bus.resp_ready_and_i = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  idx;
        logic [2:0]  len;
        logic [6:0]  src;
        logic [63:0] pay0;
        logic [63:0] pay1;
        logic        exp_err;
        logic        exp_data_v;
        logic [63:0] exp_data;
        int          chk_idx;
        logic [63:0] chk_val;
    } vec_t;

    localparam int NumVecs = 11;
    vec_t vecs [NumVecs];

    logic [63:0] f;
    logic [63:0] exp_hdr;
    logic [63:0] exp_regs [NumRegs];
    int          lat;

    initial begin
        // write reg 3 from src 5
        vecs[0]  = '{2'd1, 3'd3, 3'd1, 7'd5, 64'hDEADBEEF_00000001, 64'h0,
                     1'b0, 1'b0, 64'h0, 3, 64'hDEADBEEF_00000001};
        // read it back
        vecs[1]  = '{2'd0, 3'd3, 3'd0, 7'd5, 64'h0, 64'h0,
                     1'b0, 1'b1, 64'hDEADBEEF_00000001, 3, 64'hDEADBEEF_00000001};
        // unsupported opcode with two payload flits: drained, reg untouched
        vecs[2]  = '{2'd2, 3'd3, 3'd2, 7'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234,
                     1'b0 | 1'b1, 1'b0, 64'h0, 3, 64'hDEADBEEF_00000001};
        // write "index 9": only 3 index bits exist in the header, so 9 arrives as 1
        vecs[3]  = '{2'd1, 3'd1, 3'd1, 7'd2, 64'h01234567_89ABCDEF, 64'h0,
                     1'b0, 1'b0, 64'h0, 1, 64'h01234567_89ABCDEF};
        vecs[4]  = '{2'd0, 3'd1, 3'd0, 7'd2, 64'h0, 64'h0,
                     1'b0, 1'b1, 64'h01234567_89ABCDEF, 1, 64'h01234567_89ABCDEF};
        // write with no payload: error, nothing written
        vecs[5]  = '{2'd1, 3'd2, 3'd0, 7'd4, 64'h0, 64'h0,
                     1'b1, 1'b0, 64'h0, 2, 64'h0};
        // read carrying a payload flit: error, one flit drained
        vecs[6]  = '{2'd0, 3'd3, 3'd1, 7'd7, 64'h5555, 64'h0,
                     1'b1, 1'b0, 64'h0, 3, 64'hDEADBEEF_00000001};
        // opcode 3, no payload
        vecs[7]  = '{2'd3, 3'd0, 3'd0, 7'd1, 64'h0, 64'h0,
                     1'b1, 1'b0, 64'h0, 0, 64'h0};
        vecs[8]  = '{2'd1, 3'd7, 3'd1, 7'd3, 64'hA5A5A5A5_5A5A5A5A, 64'h0,
                     1'b0, 1'b0, 64'h0, 7, 64'hA5A5A5A5_5A5A5A5A};
        vecs[9]  = '{2'd0, 3'd0, 3'd0, 7'd9, 64'h0, 64'h0,
                     1'b0, 1'b1, 64'h0, 0, 64'h0};
        vecs[10] = '{2'd0, 3'd7, 3'd0, 7'd100, 64'h0, 64'h0,
                     1'b0, 1'b1, 64'hA5A5A5A5_5A5A5A5A, 7, 64'hA5A5A5A5_5A5A5A5A};

        my_cord              = MyCord;
        bus.cmd_v_i          = 1'b0;
        bus.cmd_flit_i       = '0;
        bus.resp_ready_and_i = 1'b0;
        reset                = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(bus.cmd_ready_and_o), 64'd0);
        check("rst_resp_v", 64'(bus.resp_v_o), 64'd0);
        check("rst_resp_flit", bus.resp_flit_o, 64'd0);
        check("rst_regs_zero", 64'(regs != '0), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 64'(bus.cmd_ready_and_o), 64'd1);

        // Table-driven transactions
        for (int i = 0; i < NumVecs; i++) begin
            send_flit(mk_hdr(7'd0, vecs[i].len, vecs[i].src, vecs[i].op, vecs[i].idx, 1'b0));
            if (vecs[i].len >= 3'd1) send_flit(vecs[i].pay0);
            if (vecs[i].len >= 3'd2) send_flit(vecs[i].pay1);
            exp_hdr = mk_hdr(vecs[i].src, {2'b00, vecs[i].exp_data_v}, MyCord, vecs[i].op,
                             vecs[i].idx, vecs[i].exp_err);
            recv_flit(f, lat);
            check($sformatf("v%0d_hdr", i), f, exp_hdr);
            check($sformatf("v%0d_hdr_latency", i), 64'(lat), 64'd0);
            if (vecs[i].exp_data_v) begin
                recv_flit(f, lat);
                check($sformatf("v%0d_data", i), f, vecs[i].exp_data);
            end
            @(negedge clk);
            check($sformatf("v%0d_back_to_ready", i), 64'(bus.cmd_ready_and_o), 64'd1);
            check($sformatf("v%0d_resp_v_idle", i), 64'(bus.resp_v_o), 64'd0);
            check($sformatf("v%0d_reg%0d", i, vecs[i].chk_idx),
                  regs[vecs[i].chk_idx*64 +: 64], vecs[i].chk_val);
        end

        // Whole bank after the table
        for (int r = 0; r < int'(NumRegs); r++) exp_regs[r] = 64'h0;
        exp_regs[1] = 64'h01234567_89ABCDEF;
        exp_regs[3] = 64'hDEADBEEF_00000001;
        exp_regs[7] = 64'hA5A5A5A5_5A5A5A5A;
        for (int r = 0; r < int'(NumRegs); r++) begin
            check($sformatf("bank_reg%0d", r), regs[r*64 +: 64], exp_regs[r]);
        end

        // Back-pressure: response held 10 cycles
        send_flit(mk_hdr(7'd0, 3'd0, 7'd33, 2'd0, 3'd3, 1'b0));
        exp_hdr = mk_hdr(7'd33, 3'd1, MyCord, 2'd0, 3'd3, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d_resp_v", c), 64'(bus.resp_v_o), 64'd1);
            check($sformatf("bp%0d_flit", c), bus.resp_flit_o, exp_hdr);
            check($sformatf("bp%0d_cmd_ready", c), 64'(bus.cmd_ready_and_o), 64'd0);
        end
        recv_flit(f, lat);
        check("bp_hdr", f, exp_hdr);
        @(negedge clk);
        check("bp_data_stall_cmd_ready", 64'(bus.cmd_ready_and_o), 64'd0);
        check("bp_data_stall_v", 64'(bus.resp_v_o), 64'd1);
        recv_flit(f, lat);
        check("bp_data", f, 64'hDEADBEEF_00000001);

        // Reset between write header and its data
        send_flit(mk_hdr(7'd0, 3'd1, 7'd5, 2'd1, 3'd0, 1'b0));
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_regs_async_zero", 64'(regs != '0), 64'd0);
        check("midrst_cmd_ready", 64'(bus.cmd_ready_and_o), 64'd0);
        check("midrst_resp_v", 64'(bus.resp_v_o), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // First flit after reset is a header: read reg 0
        send_flit(mk_hdr(7'd0, 3'd0, 7'd8, 2'd0, 3'd0, 1'b0));
        recv_flit(f, lat);
        check("postrst_hdr", f, mk_hdr(7'd8, 3'd1, MyCord, 2'd0, 3'd0, 1'b0));
        recv_flit(f, lat);
        check("postrst_data", f, 64'h0);
        send_flit(mk_hdr(7'd0, 3'd0, 7'd8, 2'd0, 3'd3, 1'b0));
        recv_flit(f, lat);
        check("postrst_hdr3", f, mk_hdr(7'd8, 3'd1, MyCord, 2'd0, 3'd3, 1'b0));
        recv_flit(f, lat);
        check("postrst_reg3_data", f, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
